queue_uart_tx: RTL and testbench
================================

QUEUE_UART_TX -- requirements
Module: queue_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 2..65535.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rst  input  1  synchronous active-high reset; sampled on rising clk.
REQ-004 Port en  input  1  drain enable; low = start no new frame.
REQ-005 Port Fp  input  10  upstream queue front (read) pointer.
REQ-006 Port Bp  input  10  upstream queue back (write) pointer.
REQ-007 Port q_out  input  8  upstream queue registered read data.
REQ-008 Port dequeue  output  1  registered one-cycle read request to upstream queue.
REQ-009 Port tx  output  1  serial line, registered, idle high.
REQ-010 Port busy  output  1  high whenever state is not IDLE.
REQ-011 Port sent_cnt  output  16  count of completed frames, wraps at 65535 -> 0.

Function
REQ-012 Queue empty SHALL be Fp == Bp (10-bit compare, wrap-around implicit); non-empty otherwise.
REQ-013 States SHALL be IDLE, REQ, LOAD, START, DATA, STOP; every state and output SHALL be registered.
REQ-014 IDLE -> REQ when en=1 and queue non-empty; otherwise remain IDLE with tx=1.
REQ-015 REQ lasts exactly one cycle; dequeue=1 only in REQ; Fp snapshot fp_snap captured on REQ entry.
REQ-016 LOAD lasts one cycle: if Fp == fp_snap+1 (mod 1024), capture q_out into shift register, tx <= 0, go START.
REQ-017 LOAD with Fp unchanged (upstream gave enqueue priority, read ignored) SHALL return to IDLE without driving tx low; retry follows normally.
REQ-018 START holds tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-019 DATA sends 8 bits LSB first, each CLKS_PER_BIT cycles; bit counter 3 bits.
REQ-020 STOP holds tx=1 for CLKS_PER_BIT cycles, then sent_cnt increments by 1 and state goes IDLE.
REQ-021 Frame = 10*CLKS_PER_BIT cycles of tx; minimum inter-frame gap after stop = 3 cycles (IDLE, REQ, LOAD) of tx=1.
REQ-022 en deassert mid-frame SHALL NOT abort the frame; it only blocks the IDLE -> REQ transition.
REQ-023 Bit-period counter SHALL be 16 bits, reload to 0 on each bit boundary; no other counter state.
REQ-024 Changes on Fp, Bp, q_out outside REQ/LOAD SHALL NOT affect the frame in flight.
REQ-025 At most one outstanding dequeue; dequeue SHALL never be high two consecutive cycles.

Reset
REQ-026 rst=1 SHALL force state IDLE, dequeue=0, tx=1, busy=0, sent_cnt=0, shift register and counters 0 on the next rising edge.
REQ-027 rst mid-frame SHALL abort immediately: tx=1 from the next edge; the aborted byte is lost and not counted.
REQ-028 rst has priority over all other inputs, including en and pointer changes in the same cycle.

Verification
REQ-029 Reset then Fp=Bp=0, en=1 -> dequeue stays 0, tx=1, busy=0 for 100 cycles.
REQ-030 CLKS_PER_BIT=4, Bp=1, q_out=8'hA5 valid after dequeue, Fp->1 -> tx = 0,1,0,1,0,0,1,0,1,1 (4 cycles each), sent_cnt=1.
REQ-031 Three bytes queued (8'h01, 8'h80, 8'hFF) -> three back-to-back frames, each 40 cycles, gaps of exactly 3 high cycles, sent_cnt=3.
REQ-032 Fp held unchanged the cycle after dequeue (enqueue priority) -> tx stays 1, state returns IDLE, second dequeue issued, byte then sent once.
REQ-033 Fp=1023, Bp=0 (wrapped, non-empty) -> dequeue issued; Fp->0 accepted as fp_snap+1 and frame sent.
REQ-034 rst pulsed during DATA bit 3 -> tx=1 next cycle, busy=0, sent_cnt=0; en=0 mid-frame -> frame completes, no new dequeue.

Source files
------------

// File: rtl/queue_uart_tx.sv
// queue_uart_tx: drains bytes from an upstream pointer-based queue and sends them as 8N1 UART frames.
module queue_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [9:0]  Fp,
  input  logic [9:0]  Bp,
  input  logic [7:0]  q_out,
  output logic        dequeue,
  output logic        tx,
  output logic        busy,
  output logic [15:0] sent_cnt
);
  typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, STOP} state_t;
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  state_t      state_q;
  logic [9:0]  fp_snap_q;
  logic [7:0]  sh_q;
  logic [2:0]  bit_q;
  logic [15:0] cnt_q;
  logic [15:0] sent_q;
  logic        dequeue_q;
  logic        tx_q;
  logic        busy_q;
  logic        last;
  logic        empty;
  assign last     = cnt_q == LAST;
  assign empty    = Fp == Bp;
  assign dequeue  = dequeue_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign sent_cnt = sent_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      fp_snap_q <= '0;
      sh_q      <= '0;
      bit_q     <= '0;
      cnt_q     <= '0;
      sent_q    <= '0;
      dequeue_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (en && !empty) begin
          state_q   <= REQ;
          dequeue_q <= 1'b1;
          busy_q    <= 1'b1;
          fp_snap_q <= Fp;
        end
        REQ: begin
          dequeue_q <= 1'b0;
          state_q   <= LOAD;
        end
        // An unmoved Fp means upstream ignored the read; retry from IDLE.
        LOAD: if (Fp == fp_snap_q + 10'd1) begin
          sh_q    <= q_out;
          tx_q    <= 1'b0;
          cnt_q   <= '0;
          state_q <= START;
        end else begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        START: if (last) begin
          cnt_q   <= '0;
          bit_q   <= '0;
          tx_q    <= sh_q[0];
          state_q <= DATA;
        end else cnt_q <= cnt_q + 16'd1;
        DATA: if (last) begin
          cnt_q <= '0;
          if (bit_q == 3'd7) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            bit_q <= bit_q + 3'd1;
            tx_q  <= sh_q[1];
            sh_q  <= {1'b0, sh_q[7:1]};
          end
        end else cnt_q <= cnt_q + 16'd1;
        STOP: if (last) begin
          cnt_q   <= '0;
          state_q <= IDLE;
          busy_q  <= 1'b0;
          sent_q  <= sent_q + 16'd1;
        end else cnt_q <= cnt_q + 16'd1;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_queue_uart_tx.sv
// tb_queue_uart_tx: directed and random drain tests against a queue model and a frame-level tx monitor.
module tb_queue_uart_tx;
  localparam int C = 4;
  logic        clk = 1'b0;
  logic        rst, en;
  logic [9:0]  Fp, Bp;
  logic [7:0]  q_out;
  logic        dequeue, tx, busy;
  logic [15:0] sent_cnt;
  logic [7:0]  mem [1024];
  logic [7:0]  exp_q [$];
  int          gaps [$];
  logic [7:0]  cur;
  int checks = 0, errors = 0;
  int pos = 0, gap = 0, frames = 0, deq_cnt = 0;
  logic in_frame = 1'b0, deq_seen = 1'b0, prev_deq = 1'b0, hold = 1'b0;

  queue_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .en(en), .Fp(Fp), .Bp(Bp), .q_out(q_out),
    .dequeue(dequeue), .tx(tx), .busy(busy), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[Bp] = b;
    Bp = Bp + 10'd1;
    exp_q.push_back(b);
  endtask

  // One clock: upstream queue answers last cycle's read, then tx is checked against the expected frame.
  task automatic tick();
    logic r;
    int k;
    r = rst;
    @(posedge clk);
    #1;
    if (deq_seen) begin
      if (hold) hold = 1'b0;
      else begin
        q_out = mem[Fp];
        Fp = Fp + 10'd1;
      end
    end
    deq_seen = dequeue;
    check("deq_single", {31'd0, dequeue & prev_deq}, 32'd0);
    prev_deq = dequeue;
    deq_cnt += int'(dequeue);
    if (r) begin
      in_frame = 1'b0;
      return;
    end
    if (!in_frame) begin
      if (tx === 1'b0) begin
        in_frame = 1'b1;
        pos = 0;
        gaps.push_back(gap);
        check("byte_pending", 32'(exp_q.size() != 0), 32'd1);
        cur = exp_q.size() != 0 ? exp_q.pop_front() : 8'hxx;
      end else gap++;
    end
    if (in_frame) begin
      k = pos / C;
      check("tx_bit", {31'd0, tx}, {31'd0, k == 0 ? 1'b0 : k <= 8 ? cur[k-1] : 1'b1});
      check("busy_in_frame", {31'd0, busy}, 32'd1);
      pos++;
      if (pos == 10 * C) begin
        in_frame = 1'b0;
        frames++;
        gap = 0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dequeue", {31'd0, dequeue}, 32'd0);
    check("rst_sent", {16'd0, sent_cnt}, 32'd0);
    frames = 0;
    deq_cnt = 0;
    deq_seen = 1'b0;
    prev_deq = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_sent(input int n, input int budget);
    int i = 0;
    while (sent_cnt !== 16'(n) && i < budget) begin
      tick();
      i++;
    end
    check("sent_cnt", {16'd0, sent_cnt}, 32'(n));
  endtask

  task automatic wait_pos(input int p, input int budget);
    int i = 0;
    while (!(in_frame && pos == p) && i < budget) begin
      tick();
      i++;
    end
    check("reach_pos", {31'd0, in_frame && pos == p}, 32'd1);
  endtask

  initial begin
    int bad, g0, d0;
    rst = 1'b1; en = 1'b0; Fp = '0; Bp = '0; q_out = '0;
    do_reset();
    en = 1'b1;
    bad = 0;
    repeat (100) begin
      tick();
      if (dequeue !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle_empty", bad, 0);

    do_reset();
    push(8'hA5);
    wait_sent(1, 200);
    check("a5_frames", frames, 1);

    do_reset();
    g0 = gaps.size();
    push(8'h01); push(8'h80); push(8'hFF);
    wait_sent(3, 400);
    check("b2b_frames", frames, 3);
    check("gap1", gaps.size() > g0 + 1 ? gaps[g0+1] : -1, 3);
    check("gap2", gaps.size() > g0 + 2 ? gaps[g0+2] : -1, 3);

    do_reset();
    hold = 1'b1;
    push(8'($urandom));
    wait_sent(1, 200);
    check("retry_deq", deq_cnt, 2);
    check("retry_frames", frames, 1);

    do_reset();
    Fp = 10'd1023; Bp = 10'd1023;
    push(8'($urandom));
    check("wrap_bp", {22'd0, Bp}, 32'd0);
    wait_sent(1, 200);
    check("wrap_fp", {22'd0, Fp}, 32'd0);
    check("wrap_deq", deq_cnt, 1);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      push(8'($urandom));
      repeat ($urandom_range(0, 50)) begin
        en = $urandom_range(0, 3) != 0;
        tick();
      end
    end
    en = 1'b1;
    wait_sent(8, 800);
    check("rand_frames", frames, 8);
    check("rand_drained", exp_q.size(), 0);

    do_reset();
    push(8'h3C);
    wait_pos(4 * C + 1, 200);
    do_reset();
    d0 = deq_cnt;
    repeat (50) tick();
    check("abort_frames", frames, 0);
    check("abort_sent", {16'd0, sent_cnt}, 32'd0);
    check("abort_no_deq", deq_cnt, d0);

    push(8'h5A); push(8'hC3);
    wait_pos(3, 200);
    en = 1'b0;
    d0 = deq_cnt;
    wait_sent(1, 200);
    repeat (50) tick();
    check("en_off_sent", {16'd0, sent_cnt}, 32'd1);
    check("en_off_deq", deq_cnt, d0);
    check("en_off_frames", frames, 1);
    en = 1'b1;
    wait_sent(2, 200);
    check("en_on_frames", frames, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
